// File: rtl/wb_core_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin grant held for the whole bus cycle,
// plus a watchdog that terminates a hung strobe with an error.
module wb_core_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  m_cyc_i,
    input  logic [1:0]  m_stb_i,
    input  logic [1:0]  m_we_i,
    input  logic [63:0] m_adr_i,
    input  logic [7:0]  m_sel_i,
    input  logic [63:0] m_dat_i,
    input  logic [5:0]  m_cti_i,
    input  logic [3:0]  m_bte_i,
    output logic [1:0]  m_ack_o,
    output logic [1:0]  m_err_o,
    output logic [1:0]  m_rty_o,
    output logic [63:0] m_dat_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,
    input  logic [31:0] s_dat_i,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    // state | meaning
    // IDLE  | no master owns the slave port
    // GNT0  | dcache (lane 0) owns the slave port
    // GNT1  | icache (lane 1) owns the slave port
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    localparam logic [TO_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state;
    logic            last;
    logic            abort;
    logic [TO_W-1:0] count;
    logic            to_pulse;
    logic            sel;
    logic            busy;
    logic            resp;

    assign sel  = (state == GNT1);
    assign busy = (state != IDLE);
    assign resp = s_ack_i | s_err_i | s_rty_i;

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_sel_o = '0;
        s_dat_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (busy) begin
            s_cyc_o = m_cyc_i[sel] & ~abort;
            s_stb_o = m_stb_i[sel] & ~abort;
            s_we_o  = m_we_i[sel];
            s_adr_o = sel ? m_adr_i[63:32] : m_adr_i[31:0];
            s_sel_o = sel ? m_sel_i[7:4]   : m_sel_i[3:0];
            s_dat_o = sel ? m_dat_i[63:32] : m_dat_i[31:0];
            s_cti_o = sel ? m_cti_i[5:3]   : m_cti_i[2:0];
            s_bte_o = sel ? m_bte_i[3:2]   : m_bte_i[1:0];
        end
    end

    assign grant_o   = {state == GNT1, state == GNT0};
    assign timeout_o = to_pulse;
    assign m_ack_o   = grant_o & {2{s_ack_i}};
    assign m_err_o   = grant_o & {2{s_err_i | to_pulse}};
    assign m_rty_o   = grant_o & {2{s_rty_i}};
    assign m_dat_o   = {2{s_dat_i}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            abort    <= 1'b0;
            count    <= '0;
            to_pulse <= 1'b0;
        end else begin
            to_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    abort <= 1'b0;
                    if (m_cyc_i == 2'b11)
                        state <= last ? GNT0 : GNT1;
                    else if (m_cyc_i[0])
                        state <= GNT0;
                    else if (m_cyc_i[1])
                        state <= GNT1;
                end
                GNT0, GNT1: begin
                    if (!m_cyc_i[sel]) begin
                        // handoff straight to a waiting master avoids an idle bubble
                        last  <= sel;
                        abort <= 1'b0;
                        count <= '0;
                        if (m_cyc_i[!sel])
                            state <= sel ? GNT0 : GNT1;
                        else
                            state <= IDLE;
                    end else if (TIMEOUT == 0 || !s_stb_o || resp) begin
                        count <= '0;
                    end else if (count == CNT_LAST) begin
                        to_pulse <= 1'b1;
                        abort    <= 1'b1;
                    end else begin
                        count <= count + TO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_core_arbiter.md
Name: wb_core_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter directly downstream of the core top.
- Consumes the packed dual-master bus from the core top: lane 0 is the data-cache BIU, lane 1 is the instruction memory hierarchy.
- Drives a single 32-bit Wishbone master port toward memory/interconnect.
- Provides round-robin arbitration, grant locking for the whole bus cycle (including bursts), and a bus-timeout watchdog that terminates hung transfers with an error.

Parameters:
- TIMEOUT, 1024, slave cycles with s_stb_o high and no ack/err/rty before forced error; 0 disables the watchdog.
- TO_W, 16, watchdog counter width; requires TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  core clock, also the Wishbone clock
- rst_n  in  1  asynchronous active-low reset
- m_cyc_i  in  2  per-master cyc; bit0 dcache, bit1 icache
- m_stb_i  in  2  per-master stb
- m_we_i  in  2  per-master write enable
- m_adr_i  in  64  {icache adr, dcache adr}
- m_sel_i  in  8  {icache sel, dcache sel}
- m_dat_i  in  64  {icache wdata, dcache wdata}
- m_cti_i  in  6  {icache cti, dcache cti}
- m_bte_i  in  4  {icache bte, dcache bte}
- m_ack_o  out  2  per-master ack
- m_err_o  out  2  per-master err
- m_rty_o  out  2  per-master rty
- m_dat_o  out  64  read data; s_dat_i broadcast to both lanes
- s_cyc_o  out  1  slave cyc
- s_stb_o  out  1  slave stb
- s_we_o  out  1  slave we
- s_adr_o  out  32  slave address
- s_sel_o  out  4  slave byte select
- s_dat_o  out  32  slave write data
- s_cti_o  out  3  slave cti
- s_bte_o  out  2  slave bte
- s_ack_i  in  1  slave ack
- s_err_i  in  1  slave err
- s_rty_i  in  1  slave rty
- s_dat_i  in  32  slave read data
- grant_o  out  2  one-hot registered grant; 00 when idle
- timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, rst_n=0): state=IDLE, grant_o=00, last=1, abort=0, counter=0.
- Output values under reset: all s_* outputs 0, and m_ack_o/m_err_o/m_rty_o/timeout_o=0.
- Mid-transfer reset discards the transfer; no ack or err is emitted.

State machine: IDLE, GNT0, GNT1.
- IDLE:
  - No m_cyc_i asserted: stay in IDLE.
  - Exactly one m_cyc_i asserted: grant that master at the next edge.
  - Both asserted: grant the master not equal to last.
  - Latency: request seen at edge N, so s_cyc_o first high in cycle N+1.
- GNTx:
  - Slave outputs are combinationally muxed from master x: s_cyc_o=m_cyc_i[x]&~abort and s_stb_o=m_stb_i[x]&~abort.
  - Remaining s_* outputs are muxed from master x lane fields.
  - s_ack_i/s_err_i/s_rty_i are routed to bit x only; the non-granted master sees 0 on all three.
  - Grant is held while m_cyc_i[x]=1, regardless of cti; bursts (cti=010) and the end-of-burst beat (cti=111) are not interrupted.
  - At an edge with m_cyc_i[x]=0: if the other master's cyc is high, go directly to its GNT state (no idle gap); otherwise go to IDLE.
  - On leaving a GNT state: last<=x and abort<=0.
- Watchdog:
  - counter increments each cycle s_stb_o=1 with none of ack/err/rty.
  - counter clears on any slave response, when s_stb_o=0, or on a state change.
  - When counter==TIMEOUT-1 and again no response: next cycle m_err_o[x]=1 and timeout_o=1 for exactly one cycle, abort<=1.
  - While abort=1: s_cyc_o/s_stb_o are forced 0 until the master drops cyc.
- Simultaneous events:
  - Slave ack in the same cycle the counter hits TIMEOUT-1: the ack wins, the counter clears, no error.
  - Slave err/rty are passed through unchanged.
  - The granted master dropping cyc in the same cycle the other raises cyc: handoff at that edge.
- Counter saturates at TIMEOUT-1; with TIMEOUT=0 the counter is held at 0 and the watchdog never fires.

Test Plan:
- Single dcache read: m_cyc_i=01, adr lane0=0x00001000, slave acks after 3 cycles with 0xDEADBEEF -> grant_o=01 one cycle after request, s_adr_o=0x00001000, m_ack_o=01 with m_dat_o[31:0]=0xDEADBEEF, m_ack_o[1]=0 throughout.
- Simultaneous requests from reset, both cyc=11 held through 2 transfers each -> first grant 01 (dcache), handoff directly to 10 on the edge dcache drops cyc, then back to 01; strict alternation.
- icache 4-beat burst (cti 010,010,010,111) while dcache requests mid-burst -> grant stays 10 for all 4 acks; dcache is granted only after icache drops cyc.
- TIMEOUT=8, slave never responds -> m_err_o[0]=1 and timeout_o=1 for one cycle, 8 cycles after stb; s_stb_o=0 afterwards; return to IDLE when master drops cyc.
- TIMEOUT=8, ack arrives in the firing cycle -> normal ack, no err, timeout_o stays 0.
- rst_n pulsed low mid-burst -> all outputs 0 immediately (async); after release, first tie goes to dcache.
